board_reset_controller: RTL and testbench

BOARD_RESET_CONTROLLER -- requirements
Module: board_reset_controller

---
 rtl/board_reset_controller.sv | 144 ++++++++++++++
 tb/tb_board_reset_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/board_reset_controller.sv
// Board-level reset/halt controller for the rvx core.
// Two raw push-buttons are synchronized and debounced. A two-state FSM holds
// the core in reset for a minimum number of cycles after power-on or after a
// reset-button press. Halt requests are forwarded only while running.
module board_reset_controller #(
  parameter int unsigned DEBOUNCE_CYCLES   = 120000,
  parameter int unsigned RESET_HOLD_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic reset_button,
  input  logic halt_button,
  output logic core_reset_n,
  output logic core_halt,
  output logic in_reset
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HoldW = $clog2(RESET_HOLD_CYCLES + 1);

  localparam logic [DbW-1:0]   DbMax   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(RESET_HOLD_CYCLES - 1);

  // Bit positions of the two buttons in the packed per-button vectors.
  localparam int BtnRst  = 0;
  localparam int BtnHalt = 1;

  typedef enum logic {StHold, StRun} state_e;

  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       db_q, db_d;
  logic [DbW-1:0]   db_cnt_q [2];
  logic [DbW-1:0]   db_cnt_d [2];

  state_e           state_q, state_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;

  logic core_reset_n_q, core_reset_n_d;
  logic core_halt_q, core_halt_d;
  logic in_reset_q, in_reset_d;

  // Two-flop synchronizers for both raw buttons.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {halt_button, reset_button};
      sync2_q <= sync1_q;
    end
  end

  // Debouncers: count consecutive mismatch cycles, flip after DEBOUNCE_CYCLES.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DbMax) begin
          db_d[i] = ~db_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  // Debounced state and counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      db_q        <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      db_q        <= db_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
    end
  end

  // FSM state register and hold counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StHold;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // FSM next state: leave HOLD after RESET_HOLD_CYCLES released cycles.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      StHold: begin
        if (db_q[BtnRst]) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HoldMax) begin
          state_d    = StRun;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      StRun: begin
        hold_cnt_d = '0;
        if (db_q[BtnRst]) begin
          state_d = StHold;
        end
      end
    endcase
  end

  // FSM outputs, computed from the next state so they change on the transition edge.
  // Halt is suppressed on the RUN-entry edge and follows the debouncer afterwards.
  always_comb begin
    core_reset_n_d = (state_d == StRun);
    in_reset_d     = (state_d == StHold);
    core_halt_d    = 1'b0;
    if (state_q == StRun && state_d == StRun) begin
      core_halt_d = db_q[BtnHalt];
    end
  end

  // Output flops keep core_reset_n free of combinational glitches.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      core_reset_n_q <= 1'b0;
      core_halt_q    <= 1'b0;
      in_reset_q     <= 1'b1;
    end else begin
      core_reset_n_q <= core_reset_n_d;
      core_halt_q    <= core_halt_d;
      in_reset_q     <= in_reset_d;
    end
  end

  assign core_reset_n = core_reset_n_q;
  assign core_halt    = core_halt_q;
  assign in_reset     = in_reset_q;

endmodule

// File: tb/tb_board_reset_controller.sv
// Scoreboard bench for board_reset_controller with DEBOUNCE_CYCLES=4 and
// RESET_HOLD_CYCLES=8. Expected output triples {core_reset_n, core_halt,
// in_reset} are queued per absolute clock edge when stimulus is applied and
// compared on the following falling edges.
module tb_board_reset_controller;

  logic clock;
  logic reset_n;
  logic reset_button;
  logic halt_button;
  logic core_reset_n;
  logic core_halt;
  logic in_reset;

  board_reset_controller #(
    .DEBOUNCE_CYCLES  (4),
    .RESET_HOLD_CYCLES(8)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .reset_button(reset_button),
    .halt_button (halt_button),
    .core_reset_n(core_reset_n),
    .core_halt   (core_halt),
    .in_reset    (in_reset)
  );

  typedef struct {
    int         cyc;
    logic [2:0] exp;
    string      tag;
  } exp_t;

  localparam logic [2:0] Hold    = 3'b001;
  localparam logic [2:0] Run     = 3'b100;
  localparam logic [2:0] RunHalt = 3'b110;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Rising-edge count since time zero; never reset.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %b expected %b (core_reset_n,core_halt,in_reset)", tag, obs, exp);
    end
  endtask

  task automatic expect_span(input int from, input int to, input logic [2:0] v, input string tag);
    for (int c = from; c <= to; c++) begin
      exp_t e;
      e.cyc = c;
      e.exp = v;
      e.tag = $sformatf("%s@%0d", tag, c);
      sb.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int n);
    do @(negedge clock); while (cyc < n);
  endtask

  // Compare queued expectations on the falling edge after their rising edge.
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      check(mon_e.tag, {core_reset_n, core_halt, in_reset}, mon_e.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int r, p, q, t, h, s, u, w, x, y;
    reset_n      = 1'b0;
    reset_button = 1'b0;
    halt_button  = 1'b0;

    // Power-on: held in reset, then 8-edge hold.
    r = 3;
    wait_cyc(r);
    check("por_reset", {core_reset_n, core_halt, in_reset}, Hold);
    reset_n = 1'b1;
    expect_span(r + 1, r + 7, Hold, "por_hold");
    expect_span(r + 8, r + 10, Run, "por_run");

    // Bounce shorter than the debounce window never reaches the FSM.
    p = r + 12;
    wait_cyc(p);
    expect_span(p + 1, p + 20, Run, "bounce");
    reset_button = 1'b1;
    wait_cyc(p + 3); reset_button = 1'b0;
    wait_cyc(p + 5); reset_button = 1'b1;
    wait_cyc(p + 8); reset_button = 1'b0;

    // Clean reset press: 2 sync + 4 debounce + 1 FSM; release: 2 + 4 + 8.
    q = p + 24;
    t = q + 20;
    wait_cyc(q);
    expect_span(q + 1, q + 6, Run, "press_run");
    expect_span(q + 7, t + 13, Hold, "press_hold");
    expect_span(t + 14, t + 16, Run, "press_rerun");
    reset_button = 1'b1;
    wait_cyc(t);
    reset_button = 1'b0;

    // Halt press and release, 7 edges each way.
    h = t + 20;
    wait_cyc(h);
    expect_span(h + 1, h + 6, Run, "halt_pre");
    expect_span(h + 7, h + 16, RunHalt, "halt_on");
    expect_span(h + 17, h + 19, Run, "halt_off");
    halt_button = 1'b1;
    wait_cyc(h + 10);
    halt_button = 1'b0;

    // Simultaneous press: reset wins, halt appears one edge after RUN entry.
    s = h + 24;
    u = s + 20;
    wait_cyc(s);
    expect_span(s + 1, s + 6, Run, "both_pre");
    expect_span(s + 7, u + 13, Hold, "both_hold");
    expect_span(u + 14, u + 14, Run, "both_entry");
    expect_span(u + 15, u + 24, RunHalt, "both_halt");
    expect_span(u + 25, u + 26, Run, "both_done");
    reset_button = 1'b1;
    halt_button  = 1'b1;
    wait_cyc(u);
    reset_button = 1'b0;
    wait_cyc(u + 18);
    halt_button = 1'b0;

    // Async reset at hold count 5 restarts the full hold.
    w = u + 30;
    x = w + 10;
    wait_cyc(w);
    expect_span(w + 1, w + 6, Run, "mid_pre");
    expect_span(w + 7, x + 10, Hold, "mid_hold");
    reset_button = 1'b1;
    wait_cyc(x);
    reset_button = 1'b0;
    wait_cyc(x + 11);
    reset_n = 1'b0;
    #1;
    check("mid_async", {core_reset_n, core_halt, in_reset}, Hold);
    expect_span(x + 13, x + 19, Hold, "mid_restart");
    expect_span(x + 20, x + 22, Run, "mid_run");
    wait_cyc(x + 12);
    reset_n = 1'b1;

    // Async reset in RUN with halt held: immediate, then halt re-debounced.
    y = x + 26;
    wait_cyc(y);
    expect_span(y + 1, y + 6, Run, "ar_pre");
    expect_span(y + 7, y + 9, RunHalt, "ar_halt");
    halt_button = 1'b1;
    wait_cyc(y + 10);
    reset_n = 1'b0;
    #1;
    check("ar_async", {core_reset_n, core_halt, in_reset}, Hold);
    expect_span(y + 12, y + 18, Hold, "ar_hold");
    expect_span(y + 19, y + 19, Run, "ar_entry");
    expect_span(y + 20, y + 22, RunHalt, "ar_halt_back");
    wait_cyc(y + 11);
    reset_n = 1'b1;
    wait_cyc(y + 23);
    halt_button = 1'b0;

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clock);
    check("drain", {2'b00, sb.size() == 0}, 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
